// File: rtl/nioshello_rom_arbiter_pkg.sv
// Shared defaults and master index type for the two-master program/data RAM arbiter.
package nioshello_rom_arbiter_pkg;

    localparam int ADDR_W_DEF  = 16;
    localparam int DATA_W_DEF  = 32;
    localparam int MAX_RUN_DEF = 4;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } master_e;

endpackage

// File: rtl/nioshello_rom_arbiter_if.sv
// Avalon-MM master port bundle; the arbiter uses the slave side, the Nios master the master side.
interface nioshello_rom_arbiter_if
    import nioshello_rom_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic [ADDR_W-1:0]   address;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W/8-1:0] byteenable;
    logic                waitrequest;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/nioshello_rom_arbiter_rr_pick.sv
// Combinational round-robin select with a cap on consecutive grants to one master.
module nioshello_rom_arbiter_rr_pick
    import nioshello_rom_arbiter_pkg::*;
#(
    parameter int MAX_RUN = MAX_RUN_DEF
) (
    input  logic [1:0] req,
    input  master_e    last_grant,
    input  logic [3:0] run_cnt,
    output logic       gnt_vld,
    output master_e    gnt_idx
);
    logic keep;

    // run_cnt==0 only occurs before the first grant after reset, so nobody holds a run yet
    // and the master other than last_grant (m0) wins the first conflict.
    assign keep = (run_cnt != 4'd0) && (run_cnt < 4'(MAX_RUN)) && req[last_grant];

    always_comb begin
        gnt_vld = |req;
        gnt_idx = M0;
        unique case (req)
            2'b01:   gnt_idx = M0;
            2'b10:   gnt_idx = M1;
            2'b11:   gnt_idx = keep ? last_grant : master_e'(~last_grant);
            default: gnt_idx = M0;
        endcase
    end
endmodule

// File: rtl/nioshello_rom_arbiter.sv
// Shares the single-port on-chip RAM between the Nios instruction (m0) and data (m1) masters.
module nioshello_rom_arbiter
    import nioshello_rom_arbiter_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int MAX_RUN = MAX_RUN_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                freeze,
    nioshello_rom_arbiter_if.slave m0,
    nioshello_rom_arbiter_if.slave m1,
    output logic [ADDR_W-1:0]   ram_address,
    output logic [DATA_W/8-1:0] ram_byteenable,
    output logic [DATA_W-1:0]   ram_writedata,
    output logic                ram_chipselect,
    output logic                ram_write,
    output logic                ram_clken,
    input  logic [DATA_W-1:0]   ram_readdata
);
    function automatic logic [3:0] sat_inc(input logic [3:0] c);
        return (c == 4'hF) ? c : c + 4'd1;
    endfunction

    master_e    last_grant, last_grant_nxt;
    logic [3:0] run_cnt, run_cnt_nxt;
    logic       rdv_pend, rdv_pend_nxt;
    master_e    rdv_owner, rdv_owner_nxt;

    logic [1:0] req;
    logic       pick_vld;
    master_e    pick_idx;
    logic       gnt;
    master_e    sel;
    logic       sel_read;

    assign req = {m1.read | m1.write, m0.read | m0.write};

    nioshello_rom_arbiter_rr_pick #(.MAX_RUN(MAX_RUN)) u_pick (
        .req        (req),
        .last_grant (last_grant),
        .run_cnt    (run_cnt),
        .gnt_vld    (pick_vld),
        .gnt_idx    (pick_idx)
    );

    // reset_n gates the grant directly so the RAM stays idle while reset is held.
    assign gnt      = pick_vld & ~freeze & reset_n;
    assign sel      = gnt ? pick_idx : M0;
    assign sel_read = (sel == M1) ? m1.read : m0.read;

    assign ram_chipselect = gnt;
    assign ram_write      = gnt & ((sel == M1) ? m1.write : m0.write);
    assign ram_address    = (sel == M1) ? m1.address    : m0.address;
    assign ram_byteenable = (sel == M1) ? m1.byteenable : m0.byteenable;
    assign ram_writedata  = (sel == M1) ? m1.writedata  : m0.writedata;
    assign ram_clken      = 1'b1;

    assign m0.waitrequest = ~(gnt && (pick_idx == M0));
    assign m1.waitrequest = ~(gnt && (pick_idx == M1));

    assign m0.readdata      = ram_readdata;
    assign m1.readdata      = ram_readdata;
    assign m0.readdatavalid = rdv_pend && (rdv_owner == M0);
    assign m1.readdatavalid = rdv_pend && (rdv_owner == M1);

    always_comb begin
        last_grant_nxt = last_grant;
        run_cnt_nxt    = run_cnt;
        rdv_pend_nxt   = 1'b0;
        rdv_owner_nxt  = rdv_owner;
        if (gnt) begin
            if (pick_idx == last_grant) begin
                run_cnt_nxt = sat_inc(run_cnt);
            end else begin
                last_grant_nxt = pick_idx;
                run_cnt_nxt    = 4'd1;
            end
            rdv_pend_nxt  = sel_read;
            rdv_owner_nxt = pick_idx;
        end
    end

    // Stage boundary: grant cycle -> read return cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= M1;
            run_cnt    <= 4'd0;
            rdv_pend   <= 1'b0;
            rdv_owner  <= M0;
        end else begin
            last_grant <= last_grant_nxt;
            run_cnt    <= run_cnt_nxt;
            rdv_pend   <= rdv_pend_nxt;
            rdv_owner  <= rdv_owner_nxt;
        end
    end
endmodule

// File: tb/tb_nioshello_rom_arbiter.sv
// Directed scoreboard bench for the RAM arbiter with a one-cycle-latency RAM model.
module tb_nioshello_rom_arbiter;
    import nioshello_rom_arbiter_pkg::*;

    localparam logic [31:0] D10  = 32'hDEADBEEF;
    localparam logic [31:0] D20  = 32'h20202020;
    localparam logic [31:0] D30  = 32'h30303030;
    localparam logic [31:0] D100 = 32'hAAAAAAAA;

    typedef struct {
        logic        m;
        logic [31:0] d;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        freeze;
    logic [15:0] ram_address;
    logic [3:0]  ram_byteenable;
    logic [31:0] ram_writedata;
    logic        ram_chipselect;
    logic        ram_write;
    logic        ram_clken;
    logic [31:0] ram_readdata;

    logic [31:0] mem [0:65535];
    exp_t        q[$];
    int          n_chk;
    int          n_pass;

    nioshello_rom_arbiter_if #(.ADDR_W(16), .DATA_W(32)) m0_bus ();
    nioshello_rom_arbiter_if #(.ADDR_W(16), .DATA_W(32)) m1_bus ();

    nioshello_rom_arbiter #(.ADDR_W(16), .DATA_W(32), .MAX_RUN(4)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .freeze         (freeze),
        .m0             (m0_bus),
        .m1             (m1_bus),
        .ram_address    (ram_address),
        .ram_byteenable (ram_byteenable),
        .ram_writedata  (ram_writedata),
        .ram_chipselect (ram_chipselect),
        .ram_write      (ram_write),
        .ram_clken      (ram_clken),
        .ram_readdata   (ram_readdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (ram_clken && ram_chipselect) begin
            if (ram_write) begin
                for (int b = 0; b < 4; b++)
                    if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
            end else begin
                ram_readdata <= mem[ram_address];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic m0_cmd(input logic rd, input logic wr, input logic [15:0] a,
                          input logic [31:0] wd, input logic [3:0] be);
        m0_bus.read = rd; m0_bus.write = wr; m0_bus.address = a;
        m0_bus.writedata = wd; m0_bus.byteenable = be;
    endtask

    task automatic m1_cmd(input logic rd, input logic wr, input logic [15:0] a,
                          input logic [31:0] wd, input logic [3:0] be);
        m1_bus.read = rd; m1_bus.write = wr; m1_bus.address = a;
        m1_bus.writedata = wd; m1_bus.byteenable = be;
    endtask

    task automatic idle_all();
        m0_cmd(1'b0, 1'b0, 16'h0, 32'h0, 4'hF);
        m1_cmd(1'b0, 1'b0, 16'h0, 32'h0, 4'hF);
    endtask

    // One cycle: check read return owed from the previous grant, then this cycle's command side.
    task automatic step(input string tag, input logic ew0, input logic ew1, input logic ecs,
                        input logic ewe, input logic [15:0] eaddr,
                        input bit push_rd, input logic pm, input logic [31:0] pdata);
        exp_t e;
        @(negedge clk);
        if (q.size() > 0) begin
            e = q.pop_front();
            chk({tag, "_rdv0"}, 32'(m0_bus.readdatavalid), 32'(e.m == 1'b0));
            chk({tag, "_rdv1"}, 32'(m1_bus.readdatavalid), 32'(e.m == 1'b1));
            chk({tag, "_rdata"}, e.m ? m1_bus.readdata : m0_bus.readdata, e.d);
        end else begin
            chk({tag, "_rdv0"}, 32'(m0_bus.readdatavalid), 32'd0);
            chk({tag, "_rdv1"}, 32'(m1_bus.readdatavalid), 32'd0);
        end
        chk({tag, "_wait0"}, 32'(m0_bus.waitrequest), 32'(ew0));
        chk({tag, "_wait1"}, 32'(m1_bus.waitrequest), 32'(ew1));
        chk({tag, "_cs"},    32'(ram_chipselect),     32'(ecs));
        chk({tag, "_we"},    32'(ram_write),          32'(ewe));
        chk({tag, "_clken"}, 32'(ram_clken),          32'd1);
        if (ecs) chk({tag, "_addr"}, 32'(ram_address), 32'(eaddr));
        if (push_rd) begin
            e.m = pm;
            e.d = pdata;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        mem[16'h0010] = D10;
        mem[16'h0020] = D20;
        mem[16'h0030] = D30;
        mem[16'h0100] = D100;
        reset_n = 1'b0;
        freeze  = 1'b0;
        m0_cmd(1'b1, 1'b0, 16'h0020, 32'h0, 4'hF);
        m1_cmd(1'b1, 1'b0, 16'h0030, 32'h0, 4'hF);
        step("rst_hold", 1, 1, 0, 0, 16'h0, 0, 0, 32'h0);
        reset_n = 1'b1;
        idle_all();
        step("idle", 1, 1, 0, 0, 16'h0, 0, 0, 32'h0);

        // Single m0 read
        m0_cmd(1'b1, 1'b0, 16'h0010, 32'h0, 4'hF);
        step("t1_gnt", 0, 1, 1, 0, 16'h0010, 1, 0, D10);
        idle_all();
        step("t1_ret", 1, 1, 0, 0, 16'h0, 0, 0, 32'h0);

        // Both masters reading continuously from reset
        reset_n = 1'b0;
        q.delete();
        step("t2_rst", 1, 1, 0, 0, 16'h0, 0, 0, 32'h0);
        reset_n = 1'b1;
        m0_cmd(1'b1, 1'b0, 16'h0020, 32'h0, 4'hF);
        m1_cmd(1'b1, 1'b0, 16'h0030, 32'h0, 4'hF);
        for (int i = 0; i < 12; i++) begin
            bit g1;
            g1 = (i >= 4) && (i < 8);
            step(g1 ? "t2_m1" : "t2_m0", g1, !g1, 1, 0, g1 ? 16'h0030 : 16'h0020, 1, g1, g1 ? D30 : D20);
        end
        idle_all();
        step("t2_tail", 1, 1, 0, 0, 16'h0, 0, 0, 32'h0);

        // Partial write then read-back next cycle
        m1_cmd(1'b0, 1'b1, 16'h0100, 32'h12345678, 4'b0011);
        step("t3_wr", 1, 0, 1, 1, 16'h0100, 0, 0, 32'h0);
        idle_all();
        m0_cmd(1'b1, 1'b0, 16'h0100, 32'h0, 4'hF);
        step("t3_rd", 0, 1, 1, 0, 16'h0100, 1, 0, 32'hAAAA5678);
        idle_all();
        step("t3_ret", 1, 1, 0, 0, 16'h0, 0, 0, 32'h0);

        // Freeze for 3 cycles with a read in flight
        m0_cmd(1'b1, 1'b0, 16'h0010, 32'h0, 4'hF);
        step("t4_pre", 0, 1, 1, 0, 16'h0010, 1, 0, D10);
        m1_cmd(1'b1, 1'b0, 16'h0030, 32'h0, 4'hF);
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) step("t4_frz", 1, 1, 0, 0, 16'h0, 0, 0, 32'h0);
        freeze = 1'b0;
        step("t4_thaw", 0, 1, 1, 0, 16'h0010, 1, 0, D10);
        idle_all();
        step("t4_ret", 1, 1, 0, 0, 16'h0, 0, 0, 32'h0);

        // Reset in the cycle after an m1 read grant
        m1_cmd(1'b1, 1'b0, 16'h0030, 32'h0, 4'hF);
        step("t5_m1", 1, 0, 1, 0, 16'h0030, 1, 1, D30);
        m0_cmd(1'b1, 1'b0, 16'h0020, 32'h0, 4'hF);
        reset_n = 1'b0;
        q.delete();
        step("t5_rst", 1, 1, 0, 0, 16'h0, 0, 0, 32'h0);
        reset_n = 1'b1;
        step("t5_first", 0, 1, 1, 0, 16'h0020, 1, 0, D20);
        idle_all();
        step("t5_ret", 1, 1, 0, 0, 16'h0, 0, 0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
